// File: rtl/axi_llc_pkg.sv
// rtl/axi_llc_pkg.sv - shared LLC configuration type and partition-table FSM states
package axi_llc_pkg;

  typedef struct packed {
    int unsigned NumLines;
    int unsigned IndexLength;
  } llc_cfg_t;

  localparam llc_cfg_t DefaultCfg = '{NumLines: 256, IndexLength: 8};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    CHECK = 2'd2,
    SWAP  = 2'd3
  } pt_state_e;

endpackage

// File: rtl/axi_llc_partition_lookup_reg.sv
// rtl/axi_llc_partition_lookup_reg.sv - single-stage valid/ready output register
module axi_llc_partition_lookup_reg #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);

  assign ready_o = !valid_o || ready_i;

  // Data only loads on an accepted beat, so a stalled result never changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (ready_o) begin
      valid_o <= valid_i;
      if (valid_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/axi_llc_partition_table.sv
// rtl/axi_llc_partition_table.sv - shadowed partition size table with prefix-sum commit
module axi_llc_partition_table
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg              = DefaultCfg,
  parameter int unsigned NumPartitions    = 16,
  parameter type         partition_size_t = logic [$clog2(Cfg.NumLines):0],
  parameter type         index_t          = logic [Cfg.IndexLength-1:0],
  parameter type         part_id_t        = logic [$clog2(NumPartitions)-1:0]
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic            cfg_commit_i,
  input  part_id_t        cfg_part_id_i,
  input  partition_size_t cfg_size_i,
  output logic            commit_done_o,
  output logic            cfg_err_o,
  input  logic            lookup_valid_i,
  output logic            lookup_ready_o,
  input  part_id_t        lookup_part_id_i,
  output logic            lookup_valid_o,
  input  logic            lookup_ready_i,
  output partition_size_t pat_size_o,
  output index_t          start_index_o,
  output partition_size_t share_size_o,
  output index_t          share_index_o,
  output logic            no_space_o
);

  localparam int unsigned P    = $clog2(Cfg.NumLines);
  localparam int unsigned AccW = P + 1 + $clog2(NumPartitions);
  localparam logic [AccW-1:0] NumLinesAcc = AccW'(Cfg.NumLines);
  localparam part_id_t        LastK       = part_id_t'(NumPartitions - 1);

  typedef struct packed {
    partition_size_t pat_size;
    index_t          start_index;
    partition_size_t share_size;
    index_t          share_index;
    logic            no_space;
  } lookup_t;

  pt_state_e       state, state_next;
  partition_size_t shadow_size  [NumPartitions];
  index_t          shadow_start [NumPartitions];
  partition_size_t active_size  [NumPartitions];
  index_t          active_start [NumPartitions];
  partition_size_t share_size;
  index_t          share_index;
  logic [AccW-1:0] acc;
  part_id_t        k;
  logic            err;
  logic            cfg_hs;
  lookup_t         lookup_d, lookup_q;

  assign cfg_hs = cfg_valid_i && cfg_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_hs && cfg_commit_i) state_next = SUM;
      SUM:     if (k == LastK) state_next = CHECK;
      CHECK:   state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o   = (state == IDLE);
    commit_done_o = (state == SWAP);
  end

  // acc is wide enough that a full table of max-size entries cannot wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumPartitions; i++) begin
        shadow_size[i]  <= '0;
        shadow_start[i] <= '0;
        active_size[i]  <= '0;
        active_start[i] <= '0;
      end
      share_size  <= partition_size_t'(Cfg.NumLines);
      share_index <= '0;
      acc         <= '0;
      k           <= '0;
      err         <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_hs && cfg_commit_i) begin
            acc <= '0;
            k   <= '0;
          end else if (cfg_hs) begin
            shadow_size[cfg_part_id_i] <= cfg_size_i;
          end
        end
        SUM: begin
          shadow_start[k] <= index_t'(acc);
          acc             <= acc + AccW'(shadow_size[k]);
          k               <= k + 1'b1;
        end
        CHECK: err <= (acc > NumLinesAcc);
        SWAP: begin
          if (!err) begin
            active_size  <= shadow_size;
            active_start <= shadow_start;
            share_index  <= index_t'(acc[P-1:0]);
            share_size   <= partition_size_t'(NumLinesAcc - acc);
            cfg_err_o    <= 1'b0;
          end else begin
            cfg_err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lookup_d.pat_size    = active_size[lookup_part_id_i];
    lookup_d.start_index = active_start[lookup_part_id_i];
    lookup_d.share_size  = share_size;
    lookup_d.share_index = share_index;
    lookup_d.no_space    = (lookup_d.pat_size == '0) && (share_size == '0);
  end

  axi_llc_partition_lookup_reg #(
    .data_t (lookup_t)
  ) u_lookup_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (lookup_valid_i),
    .ready_o (lookup_ready_o),
    .data_i  (lookup_d),
    .valid_o (lookup_valid_o),
    .ready_i (lookup_ready_i),
    .data_o  (lookup_q)
  );

  assign pat_size_o    = lookup_q.pat_size;
  assign start_index_o = lookup_q.start_index;
  assign share_size_o  = lookup_q.share_size;
  assign share_index_o = lookup_q.share_index;
  assign no_space_o    = lookup_q.no_space;

endmodule

// File: tb/tb_axi_llc_partition_table.sv
// tb/tb_axi_llc_partition_table.sv - directed bench for axi_llc_partition_table
module tb_axi_llc_partition_table;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_valid_i, cfg_ready_o, cfg_commit_i;
  logic [3:0] cfg_part_id_i;
  logic [8:0] cfg_size_i;
  logic       commit_done_o, cfg_err_o;
  logic       lookup_valid_i, lookup_ready_o;
  logic [3:0] lookup_part_id_i;
  logic       lookup_valid_o, lookup_ready_i;
  logic [8:0] pat_size_o, share_size_o;
  logic [7:0] start_index_o, share_index_o;
  logic       no_space_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  axi_llc_partition_table dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_ready_o      (cfg_ready_o),
    .cfg_commit_i     (cfg_commit_i),
    .cfg_part_id_i    (cfg_part_id_i),
    .cfg_size_i       (cfg_size_i),
    .commit_done_o    (commit_done_o),
    .cfg_err_o        (cfg_err_o),
    .lookup_valid_i   (lookup_valid_i),
    .lookup_ready_o   (lookup_ready_o),
    .lookup_part_id_i (lookup_part_id_i),
    .lookup_valid_o   (lookup_valid_o),
    .lookup_ready_i   (lookup_ready_i),
    .pat_size_o       (pat_size_o),
    .start_index_o    (start_index_o),
    .share_size_o     (share_size_o),
    .share_index_o    (share_index_o),
    .no_space_o       (no_space_o)
  );

  task automatic write_entry(input logic [3:0] id, input logic [8:0] size);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_commit_i = 1'b0; cfg_part_id_i = id; cfg_size_i = size;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_commit(output int lat);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_commit_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_commit_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      if (commit_done_o) begin lat = n; break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_lookup(input logic [3:0] id, input logic rdy_after);
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_part_id_i = id; lookup_ready_i = 1'b1;
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0; lookup_ready_i = rdy_after;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_commit_i = 1'b0; cfg_part_id_i = '0; cfg_size_i = '0;
    lookup_valid_i = 1'b0; lookup_part_id_i = '0; lookup_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    tests++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready_o); end
    tests++; if (lookup_ready_o !== 1'b1) begin fails++; $display("FAIL reset_lookup_ready: got %0b expected 1", lookup_ready_o); end
    tests++; if (lookup_valid_o !== 1'b0) begin fails++; $display("FAIL reset_lookup_valid: got %0b expected 0", lookup_valid_o); end
    tests++; if (commit_done_o !== 1'b0 || cfg_err_o !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %0b/%0b expected 0/0", commit_done_o, cfg_err_o); end
    do_lookup(4'd3, 1'b1);
    tests++; if (lookup_valid_o !== 1'b1) begin fails++; $display("FAIL reset_lookup_latency: got %0b expected 1", lookup_valid_o); end
    tests++; if (pat_size_o !== 9'd0 || start_index_o !== 8'd0) begin fails++; $display("FAIL reset_lookup_entry: got %0d/%0d expected 0/0", pat_size_o, start_index_o); end
    tests++; if (share_size_o !== 9'd256 || share_index_o !== 8'd0 || no_space_o !== 1'b0) begin fails++; $display("FAIL reset_lookup_share: got %0d/%0d/%0b expected 256/0/0", share_size_o, share_index_o, no_space_o); end
  endtask

  task automatic test_commit;
    int lat;
    write_entry(4'd0, 9'd64);
    write_entry(4'd1, 9'd32);
    write_entry(4'd15, 9'd16);
    do_lookup(4'd1, 1'b1);
    tests++; if (pat_size_o !== 9'd0) begin fails++; $display("FAIL shadow_isolated: got %0d expected 0", pat_size_o); end
    do_commit(lat);
    tests++; if (lat != 18) begin fails++; $display("FAIL commit_latency: got %0d expected 18", lat); end
    tests++; if (cfg_err_o !== 1'b0) begin fails++; $display("FAIL commit_err: got %0b expected 0", cfg_err_o); end
    do_lookup(4'd1, 1'b1);
    tests++; if (pat_size_o !== 9'd32 || start_index_o !== 8'd64) begin fails++; $display("FAIL commit_id1: got %0d/%0d expected 32/64", pat_size_o, start_index_o); end
    do_lookup(4'd15, 1'b1);
    tests++; if (pat_size_o !== 9'd16 || start_index_o !== 8'd96) begin fails++; $display("FAIL commit_id15: got %0d/%0d expected 16/96", pat_size_o, start_index_o); end
    tests++; if (share_size_o !== 9'd144 || share_index_o !== 8'd112) begin fails++; $display("FAIL commit_share: got %0d/%0d expected 144/112", share_size_o, share_index_o); end
  endtask

  task automatic test_overflow;
    int lat;
    write_entry(4'd0, 9'd200);
    write_entry(4'd1, 9'd100);
    write_entry(4'd15, 9'd0);
    do_commit(lat);
    tests++; if (cfg_err_o !== 1'b1) begin fails++; $display("FAIL overflow_err: got %0b expected 1", cfg_err_o); end
    do_lookup(4'd1, 1'b1);
    tests++; if (pat_size_o !== 9'd32 || start_index_o !== 8'd64 || share_size_o !== 9'd144 || share_index_o !== 8'd112) begin
      fails++; $display("FAIL overflow_unchanged: got %0d/%0d/%0d/%0d expected 32/64/144/112", pat_size_o, start_index_o, share_size_o, share_index_o);
    end
  endtask

  task automatic test_exact_fill;
    int lat;
    write_entry(4'd0, 9'd128);
    write_entry(4'd1, 9'd128);
    do_commit(lat);
    tests++; if (cfg_err_o !== 1'b0) begin fails++; $display("FAIL exact_err_cleared: got %0b expected 0", cfg_err_o); end
    do_lookup(4'd1, 1'b1);
    tests++; if (pat_size_o !== 9'd128 || start_index_o !== 8'd128 || no_space_o !== 1'b0) begin fails++; $display("FAIL exact_id1: got %0d/%0d/%0b expected 128/128/0", pat_size_o, start_index_o, no_space_o); end
    tests++; if (share_size_o !== 9'd0 || share_index_o !== 8'd0) begin fails++; $display("FAIL exact_share: got %0d/%0d expected 0/0", share_size_o, share_index_o); end
    do_lookup(4'd5, 1'b1);
    tests++; if (no_space_o !== 1'b1 || pat_size_o !== 9'd0) begin fails++; $display("FAIL exact_no_space: got %0b/%0d expected 1/0", no_space_o, pat_size_o); end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    write_entry(4'd0, 9'd64);
    write_entry(4'd1, 9'd32);
    do_lookup(4'd1, 1'b0);
    do_commit(lat);
    tests++; if (lat != 18) begin fails++; $display("FAIL bp_commit_latency: got %0d expected 18", lat); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (lookup_valid_o !== 1'b1 || lookup_ready_o !== 1'b0 || pat_size_o !== 9'd128 ||
          start_index_o !== 8'd128 || share_size_o !== 9'd0 || share_index_o !== 8'd0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", bad); end
    @(negedge clk_i);
    lookup_ready_i = 1'b1;
    @(posedge clk_i); #1;
    do_lookup(4'd1, 1'b1);
    tests++; if (pat_size_o !== 9'd32 || start_index_o !== 8'd64) begin fails++; $display("FAIL bp_new_entry: got %0d/%0d expected 32/64", pat_size_o, start_index_o); end
    tests++; if (share_size_o !== 9'd160 || share_index_o !== 8'd96) begin fails++; $display("FAIL bp_new_share: got %0d/%0d expected 160/96", share_size_o, share_index_o); end
  endtask

  task automatic test_reset_mid_commit;
    int pulses;
    write_entry(4'd3, 9'd50);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_commit_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_commit_i = 1'b0;
    repeat (5) @(negedge clk_i);
    tests++; if (cfg_ready_o !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b expected 0", cfg_ready_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    tests++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL mid_idle: got %0b expected 1", cfg_ready_o); end
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_i);
      if (commit_done_o) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL mid_no_done: got %0d pulses expected 0", pulses); end
    do_lookup(4'd1, 1'b1);
    tests++; if (pat_size_o !== 9'd0 || start_index_o !== 8'd0 || share_size_o !== 9'd256 || share_index_o !== 8'd0) begin
      fails++; $display("FAIL mid_reset_table: got %0d/%0d/%0d/%0d expected 0/0/256/0", pat_size_o, start_index_o, share_size_o, share_index_o);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_overflow();
    test_exact_fill();
    test_backpressure();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_llc_partition_table.md
Name: axi_llc_partition_table

Overview:
- Holds per-partition cache sizes and computes each partition's start index by prefix sum.
- Serves registered lookups that produce pat_size/start_index/share_size/share_index for the downstream index-remap stage, one lookup per descriptor.
- Sits between the AXI user-field partition-ID extraction and the index remapping logic.
- Reconfiguration is shadowed: the active table changes atomically only after a validated commit.

Parameters:
- Cfg, '0, LLC configuration struct; NumLines is used (P = $clog2(Cfg.NumLines)).
- NumPartitions, 16, number of partition-table entries.
- partition_size_t, logic, size type; must be at least P+1 bits so it can hold NumLines.
- index_t, logic, index type; Cfg.IndexLength bits.
- part_id_t, logic, partition ID type; $clog2(NumPartitions) bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_valid_i  in  1  config request valid
- cfg_ready_o  out  1  config request ready
- cfg_commit_i  in  1  1: commit shadow table; 0: write one shadow entry
- cfg_part_id_i  in  part_id_t  shadow entry to write
- cfg_size_i  in  partition_size_t  size for the shadow entry
- commit_done_o  out  1  one-cycle pulse at the end of a commit
- cfg_err_o  out  1  sticky: last commit rejected; cleared by the next successful commit
- lookup_valid_i  in  1  lookup request valid
- lookup_ready_o  out  1  lookup request ready
- lookup_part_id_i  in  part_id_t  partition ID to look up
- lookup_valid_o  out  1  lookup result valid
- lookup_ready_i  in  1  lookup result ready
- pat_size_o  out  partition_size_t  partition size (0 = uses shared region)
- start_index_o  out  index_t  partition start index
- share_size_o  out  partition_size_t  shared region size
- share_index_o  out  index_t  shared region start index
- no_space_o  out  1  pat_size==0 and share_size==0; downstream must not remap

Behaviour:
- Reset (asynchronous):
  - shadow and active sizes/starts = 0; share_size = NumLines; share_index = 0.
  - FSM = IDLE; all outputs 0, except cfg_ready_o = 1 and lookup_ready_o = 1.
- Entry write: handshake with cfg_commit_i=0 writes shadow[cfg_part_id_i] next cycle. Active table is unaffected.
- Commit: handshake with cfg_commit_i=1 in IDLE moves FSM to SUM.
- FSM states IDLE -> SUM -> CHECK -> SWAP -> IDLE:
  - SUM: counter k = 0..NumPartitions-1, one entry per cycle. shadow_start[k] = acc; acc += shadow_size[k]. acc is P+1+$clog2(NumPartitions) bits, so it cannot wrap.
  - CHECK (1 cycle): err = (acc > NumLines).
  - SWAP (1 cycle):
    - If !err: active <= shadow; share_index <= acc[P-1:0]; share_size <= NumLines - acc; cfg_err_o <= 0.
    - Else: active unchanged; cfg_err_o <= 1.
    - commit_done_o pulses in this cycle.
  - Commit latency from the handshake to the commit_done_o pulse is NumPartitions+2 cycles.
- cfg_ready_o = (state == IDLE). Config requests stall outside IDLE.
- acc == NumLines is legal: share_size = 0 and share_index = 0 (truncation of NumLines).
- Lookup pipeline: one output register with backpressure.
  - lookup_ready_o = !lookup_valid_o || lookup_ready_i.
  - On handshake, the outputs load from the active table at lookup_part_id_i on the next edge; latency 1.
  - While lookup_valid_o && !lookup_ready_i, all lookup outputs hold stable.
- Lookups proceed during commit. A lookup accepted in the SWAP cycle returns pre-swap values.
- A result already held in the output register is never altered by a swap.
- Reset mid-commit: FSM returns to IDLE, tables return to reset values, and no commit_done_o pulse is issued.

Decomposition:
- Add to axi_llc_pkg: the FSM state enum (IDLE, SUM, CHECK, SWAP). Keep the package free of per-instance widths.
- The lookup output register is a natural sub-module: a generic spill-free pipeline register (use the common-cells spill_register with Bypass=1'b0 is not required). Instantiate one single-stage valid/ready register, named axi_llc_partition_lookup_reg, carrying the result struct.
- The prefix-sum FSM stays in the top module.

Test Plan:
- Reset, then lookup id 3 -> 1 cycle later pat_size=0, start=0, share_size=NumLines (e.g. 256), share_index=0, no_space=0.
- Write sizes {64,32,0,...,16 at id 15}, then commit -> done after NumPartitions+2 (18) cycles. Lookup id1 -> size 32, start 64; lookup id15 -> start 96; share_index=112, share_size=144.
- Write sizes totalling 300 with NumLines=256, then commit -> cfg_err_o=1 and the active table is unchanged (lookup matches the prior values). A subsequent valid commit clears cfg_err_o.
- Sizes summing exactly to 256 -> share_size=0. Lookup of a size-0 id -> no_space_o=1.
- Hold lookup_ready_i=0 for 5 cycles while a commit swaps -> outputs stable with old values; lookup_ready_o=0. The next lookup returns the new values.
- Assert rst_i during SUM -> FSM IDLE, cfg_ready_o=1, no commit_done_o pulse, and lookups return reset values.
